pole_position_key_input_pio: RTL and testbench

//  Avalon-MM slave input PIO: board keys/switches to the Nios CPU. Complements the

---
 rtl/pole_position_key_input_pio_pkg.sv | 9 +
 rtl/pole_position_key_input_pio_if.sv | 11 +
 rtl/pole_position_key_input_pio_debounce.sv | 33 +++
 rtl/pole_position_key_input_pio.sv | 55 +++++
 tb/tb_pole_position_key_input_pio.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/pole_position_key_input_pio_pkg.sv
// pole_position_pio_pkg: register map and edge-type encodings shared by the PIOs
package pole_position_pio_pkg;
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pole_position_key_input_pio_if.sv
// pole_position_key_input_pio_if: Avalon-MM s1 slave port with interrupt
interface pole_position_key_input_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    modport master(output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave(input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/pole_position_key_input_pio_debounce.sv
// pole_position_debounce: one-bit synchroniser, debounce counter and edge strobes
module pole_position_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic db,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic sy, accept;
    assign sy = sync[SYNC_STAGES-1];
    assign accept = (sy != db) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise = accept && sy;
    assign fall = accept && !sy;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= {SYNC_STAGES{IDLE_LEVEL}};
            cnt  <= '0;
            db   <= IDLE_LEVEL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            cnt  <= (sy == db || accept) ? '0 : cnt + 1'b1;
            if (accept) db <= sy;
        end
    end
endmodule

// File: rtl/pole_position_key_input_pio.sv
// pole_position_key_input_pio: debounced key/switch input PIO with sticky edge capture and IRQ
module pole_position_key_input_pio
    import pole_position_pio_pkg::*;
#(
    parameter int   WIDTH           = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   EDGE_TYPE       = EDGE_FALL,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    pole_position_key_input_pio_if.slave bus
);
    logic [WIDTH-1:0] db, rise, fall, ev, irqmask, edgecap, clr;
    logic [31:0] rd_mux;
    logic wr, unused;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pole_position_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE_LEVEL(IDLE_LEVEL)
        ) u_db (
            .clk(clk),
            .reset_n(reset_n),
            .din(in_port[i]),
            .db(db[i]),
            .rise(rise[i]),
            .fall(fall[i])
        );
    end
    assign unused = ^bus.writedata;
    assign wr = bus.chipselect && !bus.write_n;
    assign ev = EDGE_TYPE == EDGE_RISE ? rise : EDGE_TYPE == EDGE_FALL ? fall : rise | fall;
    assign clr = (wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
    always_comb begin
        rd_mux = bus.address == ADDR_DATA    ? 32'(db) :
                 bus.address == ADDR_IRQMASK ? 32'(irqmask) :
                 bus.address == ADDR_EDGECAP ? 32'(edgecap) : 32'd0;
    end
    // New edges are OR-ed in after the clear so a coincident set wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask      <= '0;
            edgecap      <= '0;
            bus.readdata <= '0;
        end else begin
            if (wr && bus.address == ADDR_IRQMASK) irqmask <= bus.writedata[WIDTH-1:0];
            edgecap      <= (edgecap & ~clr) | ev;
            bus.readdata <= rd_mux;
        end
    end
    assign bus.irq = |(edgecap & irqmask);
endmodule

// File: tb/tb_pole_position_key_input_pio.sv
// tb_pole_position_key_input_pio: directed checks of debounce, edge capture, IRQ and reset abort
module tb_pole_position_key_input_pio;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] in_port = 4'hF;
    logic [3:0] r_in = 4'hF;
    logic [31:0] d;
    int vectors = 0;
    int errors = 0;
    pole_position_key_input_pio_if bus ();
    pole_position_key_input_pio_if rbus ();
    always #5 clk = ~clk;
    pole_position_key_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus));
    pole_position_key_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IDLE_LEVEL(1'b1)) dut_r (
        .clk(clk), .reset_n(reset_n), .in_port(r_in), .bus(rbus));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus.address = a;
        step(1);
        v = bus.readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        bus.address = a;
        bus.writedata = v;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b0;
        step(1);
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
    endtask

    task automatic test_reset;
        step(3);
        vectors++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h exp %h", bus.readdata, 32'h0); end
        vectors++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", bus.irq); end
        reset_n = 1'b1;
        rd(2'd0, d);
        vectors++; if (d !== 32'hF) begin errors++; $display("FAIL reset_data got %h exp %h", d, 32'hF); end
        rd(2'd3, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL reset_edgecap got %h exp %h", d, 32'h0); end
        rd(2'd1, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL reserved_read got %h exp %h", d, 32'h0); end
    endtask

    task automatic test_debounce;
        int falls = 0;
        int fall_c = -1;
        logic prev = 1'b1;
        bus.address = 2'd0;
        // final transition to 0 at c=8; db falls 6 edges later, readdata shows it one edge after that
        for (int c = 0; c < 20; c++) begin
            in_port[0] = (c < 8) && ((c & 2) != 0);
            step(1);
            if (prev && !bus.readdata[0]) begin falls++; fall_c = c; end
            prev = bus.readdata[0];
        end
        vectors++; if (falls !== 1) begin errors++; $display("FAIL bounce_fall_count got %0d exp 1", falls); end
        vectors++; if (fall_c !== 14) begin errors++; $display("FAIL bounce_fall_time got %0d exp 14", fall_c); end
        rd(2'd3, d);
        vectors++; if (d !== 32'h1) begin errors++; $display("FAIL bounce_edgecap got %h exp %h", d, 32'h1); end
        vectors++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL masked_irq got %b exp 0", bus.irq); end
    endtask

    task automatic test_irq;
        wr(2'd2, 32'h1);
        vectors++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_on_mask got %b exp 1", bus.irq); end
        wr(2'd3, 32'h1);
        vectors++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_on_clear got %b exp 0", bus.irq); end
        rd(2'd3, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL clear_edgecap got %h exp %h", d, 32'h0); end
        rd(2'd2, d);
        vectors++; if (d !== 32'h1) begin errors++; $display("FAIL irqmask_read got %h exp %h", d, 32'h1); end
    endtask

    task automatic test_back_to_back;
        in_port[0] = 1'b1;
        step(8);
        rd(2'd3, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rise_ignored got %h exp %h", d, 32'h0); end
        in_port[0] = 1'b0;
        step(5);
        wr(2'd3, 32'h1);
        vectors++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq got %b exp 1", bus.irq); end
        step(2);
        vectors++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq_hold got %b exp 1", bus.irq); end
        rd(2'd3, d);
        vectors++; if (d !== 32'h1) begin errors++; $display("FAIL set_wins_edgecap got %h exp %h", d, 32'h1); end
        wr(2'd3, 32'hF);
        vectors++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL final_clear_irq got %b exp 0", bus.irq); end
    endtask

    task automatic test_reset_mid;
        in_port = 4'b1101;
        step(4);
        reset_n = 1'b0;
        step(1);
        vectors++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL mid_reset_readdata got %h exp %h", bus.readdata, 32'h0); end
        step(1);
        reset_n = 1'b1;
        rd(2'd0, d);
        vectors++; if (d !== 32'hF) begin errors++; $display("FAIL abort_data got %h exp %h", d, 32'hF); end
        rd(2'd3, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL abort_edgecap got %h exp %h", d, 32'h0); end
        bus.address = 2'd0;
        step(3);
        vectors++; if (bus.readdata !== 32'hF) begin errors++; $display("FAIL refall_e5 got %h exp %h", bus.readdata, 32'hF); end
        step(1);
        vectors++; if (bus.readdata !== 32'hF) begin errors++; $display("FAIL refall_e6 got %h exp %h", bus.readdata, 32'hF); end
        step(1);
        vectors++; if (bus.readdata !== 32'hD) begin errors++; $display("FAIL refall_e7 got %h exp %h", bus.readdata, 32'hD); end
        rd(2'd3, d);
        vectors++; if (d !== 32'h2) begin errors++; $display("FAIL refall_edgecap got %h exp %h", d, 32'h2); end
    endtask

    task automatic test_rising;
        rbus.address = 2'd3;
        r_in[2] = 1'b0;
        step(9);
        vectors++; if (rbus.readdata !== 32'h0) begin errors++; $display("FAIL rise_mode_fall got %h exp %h", rbus.readdata, 32'h0); end
        r_in[2] = 1'b1;
        step(9);
        vectors++; if (rbus.readdata !== 32'h4) begin errors++; $display("FAIL rise_mode_rise got %h exp %h", rbus.readdata, 32'h4); end
        rbus.address = 2'd0;
        step(1);
        vectors++; if (rbus.readdata !== 32'hF) begin errors++; $display("FAIL rise_mode_data got %h exp %h", rbus.readdata, 32'hF); end
    endtask

    initial begin
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        rbus.address = 2'd0; rbus.chipselect = 1'b0; rbus.write_n = 1'b1; rbus.writedata = '0;
        #1;
        test_reset;
        test_debounce;
        test_irq;
        test_back_to_back;
        test_reset_mid;
        test_rising;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
